// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcodes, link registers, RAS op and immediate format enums.
// Latency: none (definitions only); backpressure: not applicable.
package rv32_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [4:0] LINK_X1 = 5'd1;
    localparam logic [4:0] LINK_X5 = 5'd5;

    typedef enum logic [1:0] {
        RAS_NONE     = 2'd0,
        RAS_PUSH     = 2'd1,
        RAS_POP      = 2'd2,
        RAS_POP_PUSH = 2'd3
    } ras_op_t;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_t;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        illegal;
    } dec_t;

    function automatic logic is_link(input logic [4:0] r);
        return (r == LINK_X1) || (r == LINK_X5);
    endfunction

    // Bit 31 is the sign for every format.
    function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_fmt_t f);
        logic [31:0] imm;
        case (f)
            IMM_I:   imm = {{20{i[31]}}, i[31:20]};
            IMM_S:   imm = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   imm = {i[31:12], 12'b0};
            IMM_J:   imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full, pop on empty is a no-op.
// Latency: top/empty reflect updates the cycle after push/pop; backpressure: none, always accepts.
module ras_stack
    import rv32_pkg::*;
#(
    parameter int RAS_DEPTH = 4,
    parameter int PC_W      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic            empty
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

    logic [PC_W-1:0]  mem [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_pop;
    logic [PTR_W-1:0] ptr_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_pop;
    logic [CNT_W-1:0] cnt_next;

    // Pop is applied first so pop-then-push replaces the top, or pushes onto an empty stack.
    always_comb begin
        ptr_pop = ptr;
        cnt_pop = cnt;
        if (pop && (cnt != '0)) begin
            ptr_pop = ptr - PTR_W'(1);
            cnt_pop = cnt - CNT_W'(1);
        end
        ptr_next = ptr_pop;
        cnt_next = cnt_pop;
        if (push) begin
            ptr_next = ptr_pop + PTR_W'(1);
            if (cnt_pop != FULL) begin
                cnt_next = cnt_pop + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            ptr <= ptr_next;
            cnt <= cnt_next;
            if (push) begin
                mem[ptr_next] <= push_data;
            end
        end
    end

    assign top   = mem[ptr];
    assign empty = (cnt == '0);

endmodule

// File: rtl/rv32_decode_stage.sv
// Registered RV32I decoder with return-address-stack prediction; latency 1 cycle.
// Backpressure: in_ready = !flush && (!out_valid || out_ready); a held bundle stays stable.
module rv32_decode_stage
    import rv32_pkg::*;
#(
    parameter int RAS_DEPTH = 4,
    parameter int PC_W      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [31:0]     out_imm,
    output logic [PC_W-1:0] out_pc,
    output logic            out_illegal,
    output logic [1:0]      out_ras_op,
    output logic [PC_W-1:0] out_ras_target,
    output logic            out_ras_hit
);

    dec_t            dec;
    imm_fmt_t        fmt;
    ras_op_t         ras_op;
    logic            legal;
    logic            use_rd;
    logic            use_rs1;
    logic            use_rs2;
    logic            use_f3;
    logic            use_f7;
    logic            accept;
    logic            ras_push;
    logic            ras_pop;
    logic            ras_empty;
    logic            pred_hit;
    logic [PC_W-1:0] ras_top;
    logic [PC_W-1:0] pred_target;
    logic [4:0]      f_rd;
    logic [4:0]      f_rs1;

    assign f_rd  = in_instr[11:7];
    assign f_rs1 = in_instr[19:15];

    always_comb begin
        fmt     = IMM_NONE;
        legal   = (in_instr[1:0] == 2'b11);
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_f3  = 1'b0;
        use_f7  = 1'b0;
        case (in_instr[6:0])
            OPC_LUI, OPC_AUIPC: begin
                fmt    = IMM_U;
                use_rd = 1'b1;
            end
            OPC_JAL: begin
                fmt    = IMM_J;
                use_rd = 1'b1;
            end
            OPC_JALR, OPC_LOAD, OPC_MISC_MEM, OPC_SYSTEM: begin
                fmt     = IMM_I;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_f3  = 1'b1;
            end
            OPC_OP_IMM: begin
                fmt     = IMM_I;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_f3  = 1'b1;
                // Shift-immediates (funct3 001/101) carry funct7 in the upper immediate bits.
                use_f7  = (in_instr[13:12] == 2'b01);
            end
            OPC_BRANCH: begin
                fmt     = IMM_B;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_f3  = 1'b1;
            end
            OPC_STORE: begin
                fmt     = IMM_S;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_f3  = 1'b1;
            end
            OPC_OP: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_f3  = 1'b1;
                use_f7  = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        dec         = '0;
        dec.opcode  = in_instr[6:0];
        dec.illegal = !legal;
        if (legal) begin
            dec.rd     = use_rd  ? f_rd              : '0;
            dec.rs1    = use_rs1 ? f_rs1             : '0;
            dec.rs2    = use_rs2 ? in_instr[24:20]   : '0;
            dec.funct3 = use_f3  ? in_instr[14:12]   : '0;
            dec.funct7 = use_f7  ? in_instr[31:25]   : '0;
            dec.imm    = imm_gen(in_instr, fmt);
        end
    end

    always_comb begin
        ras_op = RAS_NONE;
        if (legal && (in_instr[6:0] == OPC_JAL)) begin
            if (is_link(f_rd)) begin
                ras_op = RAS_PUSH;
            end
        end else if (legal && (in_instr[6:0] == OPC_JALR)) begin
            case ({is_link(f_rd), is_link(f_rs1)})
                2'b10:   ras_op = RAS_PUSH;
                2'b01:   ras_op = RAS_POP;
                2'b11:   ras_op = (f_rd == f_rs1) ? RAS_PUSH : RAS_POP_PUSH;
                default: ras_op = RAS_NONE;
            endcase
        end
    end

    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    assign ras_push = accept && ((ras_op == RAS_PUSH) || (ras_op == RAS_POP_PUSH));
    assign ras_pop  = accept && ((ras_op == RAS_POP)  || (ras_op == RAS_POP_PUSH));

    // Prediction is the top before this instruction's own update.
    assign pred_hit    = ((ras_op == RAS_POP) || (ras_op == RAS_POP_PUSH)) && !ras_empty;
    assign pred_target = pred_hit ? ras_top : '0;

    ras_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .PC_W      (PC_W)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (in_pc + PC_W'(4)),
        .top       (ras_top),
        .empty     (ras_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_opcode     <= '0;
            out_rd         <= '0;
            out_rs1        <= '0;
            out_rs2        <= '0;
            out_funct3     <= '0;
            out_funct7     <= '0;
            out_imm        <= '0;
            out_pc         <= '0;
            out_illegal    <= 1'b0;
            out_ras_op     <= '0;
            out_ras_target <= '0;
            out_ras_hit    <= 1'b0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            out_opcode     <= dec.opcode;
            out_rd         <= dec.rd;
            out_rs1        <= dec.rs1;
            out_rs2        <= dec.rs2;
            out_funct3     <= dec.funct3;
            out_funct7     <= dec.funct7;
            out_imm        <= dec.imm;
            out_pc         <= in_pc;
            out_illegal    <= dec.illegal;
            out_ras_op     <= ras_op;
            out_ras_target <= pred_target;
            out_ras_hit    <= pred_hit;
        end else if (flush || out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/rv32_decode_stage.md
# rv32_decode_stage

Registered RV32I decode stage with a valid/ready handshake and an integrated return-address stack (RAS) of parametrised depth. It accepts a fetched instruction and its PC, and produces register indices, funct fields, a fully sign-extended immediate for all five immediate formats, an illegal-instruction flag, the RAS hint and a predicted return target. It sits between fetch and the register-read/ALU stage and replaces the purely combinational decoder.

## Interface
- `RAS_DEPTH`, default 4: RAS entries; a power of two, ≥2.
- `PC_W`, default 32: PC and RAS entry width.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `flush` input 1: drop the held output and block acceptance this cycle.
- `in_valid` input 1: `in_instr`/`in_pc` valid.
- `in_ready` output 1: stage can accept.
- `in_instr` input 32: instruction word.
- `in_pc` input PC_W: instruction address.
- `out_valid` output 1: decoded bundle valid.
- `out_ready` input 1: consumer accepts the bundle.
- `out_opcode` output 7: instr[6:0].
- `out_rd`, `out_rs1`, `out_rs2` outputs 5 each: register indices; zero where the format has no such field.
- `out_funct3` output 3 and `out_funct7` output 7: zero where the format has no such field.
- `out_imm` output 32: sign-extended immediate.
- `out_pc` output PC_W: copy of `in_pc`.
- `out_illegal` output 1: unsupported encoding.
- `out_ras_op` output 2: 0 none, 1 push, 2 pop, 3 pop-then-push.
- `out_ras_target` output PC_W: RAS top before this instruction's update; valid when op is 2 or 3.
- `out_ras_hit` output 1: pop found a non-empty stack.

## Operation
- Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM.
- Any other opcode, or instr[1:0]≠2'b11, is illegal. An illegal instruction gives `out_illegal`=1, all fields and the immediate 0, and RAS op none.
- Immediates, with bit 31 always the sign:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
- OP/R-type passes `out_funct7`=instr[31:25]. OP-IMM shifts (funct3 001/101) also pass funct7. S and B types have rd=0. I, U and J types have rs2=0.
- Link registers are x1 and x5.
  - JAL with rd=link: push.
  - JALR, rd link and rs1 not link: push.
  - JALR, rd not link and rs1 link: pop.
  - JALR, both link and rd≠rs1: pop-then-push.
  - JALR, both link and rd=rs1: push.
- Push value is `in_pc`+4, modulo 2^PC_W.
- RAS updates on input acceptance (`in_valid && in_ready`), in speculative order.
- RAS is circular:
  - Push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Pop when empty gives `out_ras_hit`=0 and target 0; count stays 0.
  - Pop-then-push on an empty stack: the push still occurs.
- `flush` does not restore RAS contents.

## Timing
- Latency 1: a bundle accepted at edge N is on the outputs after edge N with `out_valid`=1.
- `in_ready` = !flush && (!out_valid || out_ready). This is combinational; back-to-back throughput is 1 per cycle.
- Held bundle: all outputs stay stable while `out_valid && !out_ready`.
- `flush`: `out_valid`←0 at the next edge. No input is accepted in that cycle and the RAS is unchanged in that cycle.
- Reset: `out_valid`=0, every other output 0, RAS count 0, all RAS entries 0, so `in_ready`=1 once reset is released.
- Reset mid-operation: any held bundle and all RAS state are lost immediately (asynchronous).

## Structure
- Shared package `rv32_pkg`:
  - Opcode localparams.
  - `ras_op_t` enum.
  - `imm_fmt_t` enum (I/S/B/U/J/NONE).
  - Link-register constants.
- Sub-module `ras_stack`:
  - Parameter RAS_DEPTH.
  - Inputs `push`, `pop`, `push_data`.
  - Outputs `top`, `empty`.
  - Handles wrap and saturation.
- The decode logic is combinational into the output register inside `rv32_decode_stage`.

## Test plan
- Reset then `addi x3,x1,-1` (0xFFF08193), `out_ready`=1 → next cycle: rd=3, rs1=1, funct3=0, imm=0xFFFFFFFF, illegal=0.
- `sw x2,-4(x1)` (0xFE20AE23) → imm=0xFFFFFFFC, rd=0, rs2=2. Then `beq` with offset -8 → imm=0xFFFFFFF8.
- `jal x1` at PC 0x100 → ras_op=1. Then `jalr x0,0(x1)` → ras_op=2, target=0x104, hit=1. Then another pop → hit=0, target=0.
- Five pushes with RAS_DEPTH=4 (PCs 0,4,8,12,16) → pops return 0x14, 0x10, 0xC, 0x8, then a miss.
- `out_ready`=0 for 3 cycles with `in_valid` held → outputs stable, `in_ready`=0, no RAS change. Release → exactly one acceptance per cycle.
- Instruction 0x0000007F → illegal=1, imm=0. `flush` asserted with `in_valid`=1 → `out_valid`=0 next cycle, the input is not consumed, and RAS count is unchanged.
